// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: sequencer states,
// opcode constants (also used by the main decoder) and opcode classification.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_LOAD   = 2'd0,
        CLS_STORE  = 2'd1,
        CLS_BRANCH = 2'd2,
        CLS_OTHER  = 2'd3
    } cls_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic is_legal(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic cls_t classify(input logic [6:0] opc);
        case (opc)
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_BRANCH: return CLS_BRANCH;
            default:    return CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait counter: counts unacknowledged request cycles and flags the
// cycle in which the access must be abandoned.
module seq_wait_timer #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             waiting,
    input  logic             ack,
    output logic             expired,
    output logic [CNT_W-1:0] count
);

    localparam bit             ENABLE = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    // Clearing whenever no request is pending (or it completes) gives a zero
    // count on every entry to FETCH or MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!waiting || ack) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expired = ENABLE && waiting && !ack && (count == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives the shared memory port, IR/PC load strobes and register write.
module core_sequencer
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_ifetch,
    output logic       ir_load,
    output logic       pc_load,
    output logic       reg_w_en,
    output logic       instret,
    output logic       trap,
    output state_t     state_dbg
);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic             waiting;
    logic             timeout;
    logic [CNT_W-1:0] wait_count;

    // Derived from state only, so the timer never sees a path through opcode.
    assign waiting = (state_q == FETCH) || (state_q == MEM);

    seq_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting),
        .ack     (mem_ack),
        .expired (timeout),
        .count   (wait_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cls_q   <= CLS_OTHER;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_ifetch = 1'b0;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        reg_w_en   = 1'b0;
        instret    = 1'b0;
        trap       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end
            DECODE: begin
                if (is_legal(opcode)) begin
                    cls_d   = classify(opcode);
                    state_d = EXEC;
                end else begin
                    state_d = TRAP;
                end
            end
            EXEC: begin
                case (cls_q)
                    CLS_LOAD, CLS_STORE: state_d = MEM;
                    CLS_BRANCH: begin
                        pc_load = 1'b1;
                        instret = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == CLS_STORE);
                if (mem_ack) begin
                    if (cls_q == CLS_STORE) begin
                        pc_load = 1'b1;
                        instret = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end
            WB: begin
                reg_w_en = 1'b1;
                pc_load  = 1'b1;
                instret  = 1'b1;
                state_d  = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: state_d = TRAP;
        endcase
        // Reset parks the FSM in FETCH; keep the port quiet until it is released.
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_ifetch = 1'b0;
            ir_load    = 1'b0;
            pc_load    = 1'b0;
            reg_w_en   = 1'b0;
            instret    = 1'b0;
            trap       = 1'b0;
        end
    end

    assign state_dbg = state_q;

endmodule
